// File: rtl/comb_gates_4b_pairwise_arb_pkg.sv
// Shared types for the arbitrated 4-bit pairwise-gates unit.
package comb_gates_4b_pairwise_arb_pkg;

  localparam int unsigned NREQ_MAX = 8;

  typedef logic [3:0] gates_in_t;

  typedef struct packed {
    logic [2:0] g_and;
    logic [2:0] g_or;
    logic [2:0] g_xnor;
  } gates_out_t;

  typedef enum logic {StEmpty, StFull} buf_state_e;

endpackage

// File: rtl/comb_gates_4b_pairwise_arb_gates.sv
// Purely combinational pairwise gates over adjacent bits of a 4-bit operand.
module comb_gates_4b_pairwise
  import comb_gates_4b_pairwise_arb_pkg::*;
(
  input  gates_in_t  operand,
  output gates_out_t result
);

  always_comb begin
    result = '0;
    for (int k = 0; k < 3; k++) begin
      result.g_and[k]  = operand[k] & operand[k+1];
      result.g_or[k]   = operand[k] | operand[k+1];
      result.g_xnor[k] = ~(operand[k] ^ operand[k+1]);
    end
  end

endmodule

// File: rtl/comb_gates_4b_pairwise_arb.sv
// Round-robin shares one pairwise-gates unit among NREQ requesters; the result lands in a
// single-entry response buffer with val/rdy handshake.
module comb_gates_4b_pairwise_arb
  import comb_gates_4b_pairwise_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [4*NREQ-1:0] req_in_,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [IDW-1:0]    resp_id,
  output logic [2:0]        resp_and,
  output logic [2:0]        resp_or,
  output logic [2:0]        resp_xnor
);

  buf_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q;
  gates_out_t     data_q;

  logic           can_accept;
  logic           any_req;
  logic           grant_any;
  logic [IDW-1:0] win;
  logic [4:0]     scan_sum;
  logic [IDW-1:0] scan_idx;
  gates_in_t      mux_in;
  gates_out_t     gates_res;

  // Accept a new operand when empty, or when the current one leaves this cycle.
  assign can_accept = (state_q == StEmpty) | resp_rdy;

  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      scan_sum = 5'(ptr_q) + 5'(j);
      scan_idx = IDW'(scan_sum % 5'(NREQ));
      if (!any_req && req_val[scan_idx]) begin
        any_req = 1'b1;
        win     = scan_idx;
      end
    end
  end

  // Reset term keeps grants off while reset is held low.
  assign grant_any = reset && can_accept && any_req;

  always_comb begin
    req_rdy = '0;
    if (grant_any) req_rdy[win] = 1'b1;
  end

  always_comb begin
    mux_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) mux_in = req_in_[4*i +: 4];
    end
  end

  comb_gates_4b_pairwise u_gates (
    .operand (mux_in),
    .result  (gates_res)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant_any) begin
      state_d = StFull;
      ptr_d   = IDW'((5'(win) + 5'd1) % 5'(NREQ));
    end else if (resp_rdy) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant_any) begin
        id_q   <= win;
        data_q <= gates_res;
      end
    end
  end

  assign resp_val  = (state_q == StFull);
  assign resp_id   = id_q;
  assign resp_and  = data_q.g_and;
  assign resp_or   = data_q.g_or;
  assign resp_xnor = data_q.g_xnor;

endmodule

// File: tb/tb_comb_gates_4b_pairwise_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_comb_gates_4b_pairwise_arb;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_val;
  logic [3:0]  req_rdy;
  logic [15:0] req_in_;
  logic        resp_val;
  logic        resp_rdy;
  logic [1:0]  resp_id;
  logic [2:0]  resp_and, resp_or, resp_xnor;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the buffer and priority pointer
  logic       m_valid;
  logic [1:0] m_id;
  logic [8:0] m_data;
  int         m_ptr;

  always #5 clk = ~clk;

  comb_gates_4b_pairwise_arb #(.NREQ(4), .IDW(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_in_   (req_in_),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_id   (resp_id),
    .resp_and  (resp_and),
    .resp_or   (resp_or),
    .resp_xnor (resp_xnor)
  );

  function automatic logic [8:0] ref_gates(input logic [3:0] v);
    logic [2:0] a, o, x;
    for (int k = 0; k < 3; k++) begin
      a[k] = v[k] && v[k+1];
      o[k] = v[k] || v[k+1];
      x[k] = (v[k] == v[k+1]);
    end
    return {a, o, x};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int         w;
    logic [3:0] rdy;
    logic       acc;
    @(negedge clk);
    w   = -1;
    rdy = '0;
    acc = !m_valid || resp_rdy;
    if (reset && acc) begin
      for (int j = 0; j < N; j++) begin
        int i;
        i = (m_ptr + j) % N;
        if (w < 0 && req_val[i]) w = i;
      end
    end
    if (w >= 0) rdy[w] = 1'b1;
    chk("req_rdy", 32'(req_rdy), 32'(rdy));
    chk("resp_val", 32'(resp_val), 32'(m_valid));
    chk("resp_id", 32'(resp_id), 32'(m_id));
    chk("resp_data", 32'({resp_and, resp_or, resp_xnor}), 32'(m_data));
    @(posedge clk);
    if (!reset) begin
      m_valid = 1'b0;
      m_id    = '0;
      m_data  = '0;
      m_ptr   = 0;
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_id    = w[1:0];
      m_data  = ref_gates(req_in_[4*w +: 4]);
      m_ptr   = (w + 1) % N;
    end else if (resp_rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [3:0] first_id;
    m_valid = 1'b0; m_id = '0; m_data = '0; m_ptr = 0;
    reset = 1'b0; req_val = 4'hF; req_in_ = 16'h0; resp_rdy = 1'b1;
    @(posedge clk); #1;

    // Reset held with all requests valid
    cycle();
    cycle();
    chk("rst_val", 32'(resp_val), 32'd0);
    chk("rst_data", 32'({resp_and, resp_or, resp_xnor}), 32'd0);
    reset = 1'b1; #1;
    chk("rst_ptr_grant0", 32'(req_rdy), 32'b0001);
    req_val = 4'b0001; req_in_ = 16'h000B;
    cycle();

    // Single request 1011 from requester 0
    chk("single_val", 32'(resp_val), 32'd1);
    chk("single_id", 32'(resp_id), 32'd0);
    chk("single_and", 32'(resp_and), 32'b001);
    chk("single_or", 32'(resp_or), 32'b111);
    chk("single_xnor", 32'(resp_xnor), 32'b001);

    // Round robin between requesters 0 and 1
    req_val = 4'b0011; req_in_ = 16'h0006;
    cycle();
    first_id = {2'b00, resp_id};
    for (int c = 0; c < 4; c++) begin
      chk("rr_alt", 32'(resp_id), 32'(first_id[1:0] ^ 2'(c & 1)));
      chk("rr_data", 32'({resp_and, resp_or, resp_xnor}),
          (resp_id == 2'd0) ? 32'b010_111_010 : 32'b000_000_111);
      cycle();
    end

    // Backpressure
    req_val = 4'b0000; cycle();
    req_val = 4'b0001; req_in_ = 16'h000F; resp_rdy = 1'b0;
    cycle();
    req_in_ = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      chk("bp_req_rdy", 32'(req_rdy), 32'd0);
      chk("bp_hold", 32'({resp_and, resp_or, resp_xnor}), 32'b111_111_111);
      cycle();
    end
    resp_rdy = 1'b1; #1;
    chk("bp_release_grant", 32'(req_rdy), 32'b0001);
    cycle();
    chk("bp_refill_val", 32'(resp_val), 32'd1);
    chk("bp_refill_data", 32'({resp_and, resp_or, resp_xnor}), 32'b000_000_111);

    // Pointer wrap
    reset = 1'b0; req_val = 4'b0000; cycle();
    reset = 1'b1; req_val = 4'b1000; cycle();
    chk("wrap_id3", 32'(resp_id), 32'd3);
    req_val = 4'b0001; cycle();
    chk("wrap_id0", 32'(resp_id), 32'd0);
    req_val = 4'b0011; #1;
    chk("wrap_ptr1", 32'(req_rdy), 32'b0010);
    cycle();

    // Exhaustive sweep through requester 2
    req_val = 4'b0100;
    for (int v = 0; v < 16; v++) begin
      req_in_ = 16'(v) << 8;
      cycle();
      chk("sweep", 32'({resp_and, resp_or, resp_xnor}), 32'(ref_gates(4'(v))));
    end

    // Mid-operation reset while full
    resp_rdy = 1'b0; req_val = 4'b0010; req_in_ = 16'h0050; cycle();
    reset = 1'b0; cycle();
    chk("midrst_val", 32'(resp_val), 32'd0);
    reset = 1'b1; resp_rdy = 1'b1; req_val = 4'hF; #1;
    chk("midrst_ptr", 32'(req_rdy), 32'b0001);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 40) != 0);
      req_val  = 4'($urandom);
      req_in_  = 16'($urandom);
      resp_rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
